leve1_axir_arb: RTL and testbench
=================================

Name: leve1_axir_arb

Overview:
- Two-requester arbiter for a single AXI read initiator port.
- Shares one memory read channel between the instruction fetch unit (S0) and the load/store unit (S1).
- Sits between the LEVE1 front end / LSU and the memory-side AXI read target.
- At most one burst is outstanding; owner selection is round-robin, or fixed priority when configured.

Parameters:
- FIXED_PRIO, 0: 1 = S0 always wins a contested grant; 0 = round-robin.
- MAX_LEN, 8'd15: largest ARLEN accepted. A larger request is still forwarded, but OERR is set.

Ports:
- CLK  in  1: clock, all logic on rising edge.
- RSTn  in  1: synchronous active-low reset.
- S0  AXIR.targ  intf: read target port for the instruction fetch requester.
- S1  AXIR.targ  intf: read target port for the LSU requester.
- M  AXIR.init  intf: read initiator port to memory.
- OBUSY  out  1: high in every state except IDLE.
- OGNT  out  2: one-hot current owner; 2'b00 in IDLE.
- OERR  out  1: sticky protocol-error flag.

Behaviour:
- Reset (RSTn low at a clock edge):
  - state=IDLE, last_gnt=S1 (so S0 wins the first contested round-robin grant), beat counter=0.
  - OBUSY=0, OGNT=0, OERR=0.
  - All VALID/READY outputs are low while in reset and IDLE.
- Reset mid-burst aborts ownership immediately. The memory side must also be reset; no drain is performed.
- States: IDLE, AR0, AR1, R0, R1. Registered state; channel muxing is combinational from state.
- IDLE:
  - M.ARVALID=0; S0.ARREADY=S1.ARREADY=0.
  - Only S0.ARVALID -> AR0. Only S1 -> AR1. Both -> pick by FIXED_PRIO, else the port not equal to last_gnt. None -> stay.
  - Arbitration costs exactly 1 bubble cycle: a request seen in cycle N appears on M.ARVALID in N+1.
- ARx:
  - M.AR* = Sx.AR* (ARADDR, ARLEN, ARBURST, ARSIZE pass through). Sx.ARREADY = M.ARREADY; the other port's ARREADY=0.
  - On M.ARVALID & M.ARREADY: latch exp = ARLEN, clear beat counter, go to Rx, set last_gnt=x.
  - The state cannot leave ARx before the handshake, so M.ARVALID never drops while pending (AXI rule preserved even if the requester misbehaves; OERR set if Sx.ARVALID falls before ARREADY).
- Rx:
  - M.RDATA/RRESP/RLAST go to Sx. Sx.RVALID = M.RVALID; M.RREADY = Sx.RREADY. The other port's RVALID=0.
  - Each R handshake increments the 8-bit beat counter.
  - On the handshake with M.RLAST=1 -> IDLE the following cycle.
  - No AR acceptance during Rx for either port.
- Minimum turnaround:
  - Back-to-back requests from the same port: 1 idle cycle after the last R beat before the next AR.
  - A waiting opposite port gets the next grant under round-robin.
- OERR (sticky until reset) is set on any of:
  - RLAST seen on a beat where counter != exp.
  - counter == exp with RLAST=0.
  - ARLEN > MAX_LEN at AR handshake.
  - Requester ARVALID retraction in ARx.
  - M.RVALID while in IDLE/ARx.
- RRESP is passed through unmodified. Errors on the response are the requester's concern.
- Width rules: beat counter and exp are 8 bits; the counter does not wrap in legal operation (max 16 beats).

Decomposition:
- Shared package (defs): state enum arb_st_t {IDLE, AR0, AR1, R0, R1}.
- Shared package (defs): AXI_BURST_* constants already defined; MAX_LEN default constant LEVE_AXI_MAXLEN.
- Optional sub-module leve1_rr_pick: 2-way round-robin/fixed-priority picker (req[1:0], last_gnt, fixed -> gnt[1:0]).
- Everything else stays in one module.

Test Plan:
1. Single S0 WRAP burst: S0 ARADDR=0x8000_0010, ARLEN=3; memory returns 4 beats with RLAST on beat 4.
   -> M.ARVALID rises the cycle after S0.ARVALID; S0 gets 4 beats; OGNT=01 during the burst; IDLE the cycle after RLAST; OERR=0.
2. Simultaneous S0 and S1 requests, FIXED_PRIO=0, from reset.
   -> S0 served first, then S1 with exactly 1 IDLE cycle between; S1.RVALID stays 0 throughout S0's burst.
3. Continuous requests on both ports for 6 bursts.
   -> Grant order S0,S1,S0,S1,S0,S1; with FIXED_PRIO=1 the order is S0 x6 while S0 stays asserted.
4. M.ARREADY held low 5 cycles in AR1, with S1.ARVALID dropping after 2 cycles.
   -> M.ARVALID stays high all 5 cycles; OERR=1 after the retraction; handshake completes; state moves to R1.
5. ARLEN=3 but memory asserts RLAST on beat 2.
   -> OERR=1 the next cycle; state returns to IDLE; S0 still sees RLAST.
6. RSTn low for 1 cycle during R0 beat 2.
   -> Next cycle: state IDLE, OBUSY=0, OGNT=0, OERR=0, all READY/VALID outputs 0.

Source files
------------

// File: rtl/leve1_axir_arb_pkg.sv
// Shared definitions for the LEVE1 two-requester AXI read arbiter.
// Holds the arbiter state encoding and the AXI burst/length constants.
package leve1_axir_arb_pkg;

  typedef enum logic [2:0] {IDLE, AR0, AR1, R0, R1} arb_st_t;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [7:0] LEVE_AXI_MAXLEN = 8'd15;

endpackage

// File: rtl/leve1_rr_pick.sv
// Two-way grant picker: round-robin against last_gnt, or S0-first when fixed is set.
// Purely combinational; a lone request is always granted.
module leve1_rr_pick (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       fixed,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // last_gnt=1 means S1 owned the previous burst, so S0 is next in line.
    if (req == 2'b11) gnt = (fixed || last_gnt) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/leve1_axir_arb.sv
// Shares one AXI read initiator between instruction fetch (S0) and LSU (S1), one burst at a time.
// One bubble cycle from request to M.ARVALID; AR and R handshakes pass straight through to the owner.
module leve1_axir_arb
  import leve1_axir_arb_pkg::*;
#(
  parameter bit         FIXED_PRIO = 1'b0,
  parameter logic [7:0] MAX_LEN    = LEVE_AXI_MAXLEN,
  parameter int         AW         = 32,
  parameter int         DW         = 32
) (
  input  logic          CLK,
  input  logic          RSTn,

  input  logic          s0_arvalid,
  output logic          s0_arready,
  input  logic [AW-1:0] s0_araddr,
  input  logic [7:0]    s0_arlen,
  input  logic [1:0]    s0_arburst,
  input  logic [2:0]    s0_arsize,
  output logic          s0_rvalid,
  input  logic          s0_rready,
  output logic [DW-1:0] s0_rdata,
  output logic [1:0]    s0_rresp,
  output logic          s0_rlast,

  input  logic          s1_arvalid,
  output logic          s1_arready,
  input  logic [AW-1:0] s1_araddr,
  input  logic [7:0]    s1_arlen,
  input  logic [1:0]    s1_arburst,
  input  logic [2:0]    s1_arsize,
  output logic          s1_rvalid,
  input  logic          s1_rready,
  output logic [DW-1:0] s1_rdata,
  output logic [1:0]    s1_rresp,
  output logic          s1_rlast,

  output logic          m_arvalid,
  input  logic          m_arready,
  output logic [AW-1:0] m_araddr,
  output logic [7:0]    m_arlen,
  output logic [1:0]    m_arburst,
  output logic [2:0]    m_arsize,
  input  logic          m_rvalid,
  output logic          m_rready,
  input  logic [DW-1:0] m_rdata,
  input  logic [1:0]    m_rresp,
  input  logic          m_rlast,

  output logic          OBUSY,
  output logic [1:0]    OGNT,
  output logic          OERR
);

  arb_st_t    state;
  logic       last_gnt;
  logic [7:0] cnt;
  logic [7:0] exp_len;
  logic [1:0] pick;

  logic in_ar, in_r, sel1, cur_arvalid, ar_hs, r_hs;

  leve1_rr_pick u_pick (
    .req      ({s1_arvalid, s0_arvalid}),
    .last_gnt (last_gnt),
    .fixed    (FIXED_PRIO),
    .gnt      (pick)
  );

  // Handshake-visible outputs are forced low while RSTn is asserted.
  always_comb begin
    in_ar       = (state == AR0) || (state == AR1);
    in_r        = (state == R0)  || (state == R1);
    sel1        = (state == AR1) || (state == R1);
    cur_arvalid = sel1 ? s1_arvalid : s0_arvalid;

    m_arvalid   = RSTn && in_ar;
    m_araddr    = sel1 ? s1_araddr  : s0_araddr;
    m_arlen     = sel1 ? s1_arlen   : s0_arlen;
    m_arburst   = sel1 ? s1_arburst : s0_arburst;
    m_arsize    = sel1 ? s1_arsize  : s0_arsize;
    s0_arready  = RSTn && (state == AR0) && m_arready;
    s1_arready  = RSTn && (state == AR1) && m_arready;

    m_rready    = RSTn && (((state == R0) && s0_rready) || ((state == R1) && s1_rready));
    s0_rvalid   = RSTn && (state == R0) && m_rvalid;
    s1_rvalid   = RSTn && (state == R1) && m_rvalid;
    s0_rdata    = m_rdata;
    s1_rdata    = m_rdata;
    s0_rresp    = m_rresp;
    s1_rresp    = m_rresp;
    s0_rlast    = m_rlast;
    s1_rlast    = m_rlast;

    ar_hs       = m_arvalid && m_arready;
    r_hs        = m_rvalid && m_rready;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      cnt      <= 8'd0;
      exp_len  <= 8'd0;
      OBUSY    <= 1'b0;
      OGNT     <= 2'b00;
      OERR     <= 1'b0;
    end else begin
      if (!in_r && m_rvalid) OERR <= 1'b1;
      case (state)
        IDLE: begin
          if (pick[0]) begin
            state <= AR0;
            OBUSY <= 1'b1;
            OGNT  <= 2'b01;
          end else if (pick[1]) begin
            state <= AR1;
            OBUSY <= 1'b1;
            OGNT  <= 2'b10;
          end
        end
        AR0, AR1: begin
          // The owner is held until the handshake even if its request is withdrawn.
          if (!cur_arvalid) OERR <= 1'b1;
          if (ar_hs) begin
            exp_len  <= m_arlen;
            cnt      <= 8'd0;
            last_gnt <= sel1;
            state    <= sel1 ? R1 : R0;
            if (m_arlen > MAX_LEN) OERR <= 1'b1;
          end
        end
        R0, R1: begin
          if (r_hs) begin
            cnt <= cnt + 8'd1;
            if (m_rlast) begin
              if (cnt != exp_len) OERR <= 1'b1;
              state <= IDLE;
              OBUSY <= 1'b0;
              OGNT  <= 2'b00;
            end else if (cnt == exp_len) begin
              OERR <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          OBUSY <= 1'b0;
          OGNT  <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leve1_axir_arb.sv
// Directed bench: instance 0 is round-robin, instance 1 is fixed-priority; both share clock and reset.
module tb_leve1_axir_arb;
  import leve1_axir_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        s_arvalid [2][2];
  logic        s_arready [2][2];
  logic [31:0] s_araddr  [2][2];
  logic [7:0]  s_arlen   [2][2];
  logic [1:0]  s_arburst [2][2];
  logic [2:0]  s_arsize  [2][2];
  logic        s_rvalid  [2][2];
  logic        s_rready  [2][2];
  logic [31:0] s_rdata   [2][2];
  logic [1:0]  s_rresp   [2][2];
  logic        s_rlast   [2][2];

  logic        m_arvalid [2];
  logic        m_arready [2];
  logic [31:0] m_araddr  [2];
  logic [7:0]  m_arlen   [2];
  logic [1:0]  m_arburst [2];
  logic [2:0]  m_arsize  [2];
  logic        m_rvalid  [2];
  logic        m_rready  [2];
  logic [31:0] m_rdata   [2];
  logic [1:0]  m_rresp   [2];
  logic        m_rlast   [2];
  logic        obusy     [2];
  logic [1:0]  ognt      [2];
  logic        oerr      [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    leve1_axir_arb #(.FIXED_PRIO(g == 1)) dut (
      .CLK        (clk),
      .RSTn       (rst_n),
      .s0_arvalid (s_arvalid[g][0]), .s0_arready (s_arready[g][0]),
      .s0_araddr  (s_araddr[g][0]),  .s0_arlen   (s_arlen[g][0]),
      .s0_arburst (s_arburst[g][0]), .s0_arsize  (s_arsize[g][0]),
      .s0_rvalid  (s_rvalid[g][0]),  .s0_rready  (s_rready[g][0]),
      .s0_rdata   (s_rdata[g][0]),   .s0_rresp   (s_rresp[g][0]),
      .s0_rlast   (s_rlast[g][0]),
      .s1_arvalid (s_arvalid[g][1]), .s1_arready (s_arready[g][1]),
      .s1_araddr  (s_araddr[g][1]),  .s1_arlen   (s_arlen[g][1]),
      .s1_arburst (s_arburst[g][1]), .s1_arsize  (s_arsize[g][1]),
      .s1_rvalid  (s_rvalid[g][1]),  .s1_rready  (s_rready[g][1]),
      .s1_rdata   (s_rdata[g][1]),   .s1_rresp   (s_rresp[g][1]),
      .s1_rlast   (s_rlast[g][1]),
      .m_arvalid  (m_arvalid[g]),    .m_arready  (m_arready[g]),
      .m_araddr   (m_araddr[g]),     .m_arlen    (m_arlen[g]),
      .m_arburst  (m_arburst[g]),    .m_arsize   (m_arsize[g]),
      .m_rvalid   (m_rvalid[g]),     .m_rready   (m_rready[g]),
      .m_rdata    (m_rdata[g]),      .m_rresp    (m_rresp[g]),
      .m_rlast    (m_rlast[g]),
      .OBUSY      (obusy[g]),
      .OGNT       (ognt[g]),
      .OERR       (oerr[g])
    );
  end

  // Each cycle: inputs change 1 time unit after the rising edge, outputs are read 2 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        s_arvalid[i][p] = 1'b0;
        s_araddr[i][p]  = 32'h0;
        s_arlen[i][p]   = 8'd0;
        s_arburst[i][p] = AXI_BURST_INCR;
        s_arsize[i][p]  = 3'd2;
        s_rready[i][p]  = 1'b1;
      end
      m_arready[i] = 1'b0;
      m_rvalid[i]  = 1'b0;
      m_rdata[i]   = 32'h0;
      m_rresp[i]   = 2'b00;
      m_rlast[i]   = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    s_arvalid[0][0] = 1'b1;
    m_arready[0]    = 1'b1;
    m_rvalid[0]     = 1'b1;
    step();
    step();
    #2;
    n_tests++; if (obusy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_obusy got=%b want=0", obusy[0]); end
    n_tests++; if (ognt[0] !== 2'b00) begin n_fail++; $display("FAIL rst_ognt got=%b want=00", ognt[0]); end
    n_tests++; if (oerr[0] !== 1'b0) begin n_fail++; $display("FAIL rst_oerr got=%b want=0", oerr[0]); end
    n_tests++; if (m_arvalid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_m_arvalid got=%b want=0", m_arvalid[0]); end
    n_tests++; if (s_arready[0][0] !== 1'b0) begin n_fail++; $display("FAIL rst_s0_arready got=%b want=0", s_arready[0][0]); end
    n_tests++; if (s_rvalid[0][0] !== 1'b0) begin n_fail++; $display("FAIL rst_s0_rvalid got=%b want=0", s_rvalid[0][0]); end
    n_tests++; if (m_rready[0] !== 1'b0) begin n_fail++; $display("FAIL rst_m_rready got=%b want=0", m_rready[0]); end
    clear_inputs();
  endtask

  task automatic test_single_wrap();
    do_reset();
    s_arvalid[0][0] = 1'b1;
    s_araddr[0][0]  = 32'h8000_0010;
    s_arlen[0][0]   = 8'd3;
    s_arburst[0][0] = AXI_BURST_WRAP;
    #2;
    n_tests++; if (m_arvalid[0] !== 1'b0) begin n_fail++; $display("FAIL t1_bubble got=%b want=0", m_arvalid[0]); end
    step();
    m_arready[0] = 1'b1;
    #2;
    n_tests++; if (m_arvalid[0] !== 1'b1) begin n_fail++; $display("FAIL t1_arvalid got=%b want=1", m_arvalid[0]); end
    n_tests++; if (m_araddr[0] !== 32'h8000_0010) begin n_fail++; $display("FAIL t1_araddr got=%h want=80000010", m_araddr[0]); end
    n_tests++; if (m_arlen[0] !== 8'd3 || m_arburst[0] !== AXI_BURST_WRAP) begin n_fail++; $display("FAIL t1_arlen_burst got=%0d/%b want=3/10", m_arlen[0], m_arburst[0]); end
    n_tests++; if (s_arready[0][0] !== 1'b1 || s_arready[0][1] !== 1'b0) begin n_fail++; $display("FAIL t1_arready got=%b%b want=01", s_arready[0][1], s_arready[0][0]); end
    step();
    s_arvalid[0][0] = 1'b0;
    m_arready[0]    = 1'b0;
    for (int b = 0; b < 4; b++) begin
      m_rvalid[0] = 1'b1;
      m_rdata[0]  = 32'hD000_0000 + b;
      m_rlast[0]  = (b == 3);
      #2;
      n_tests++; if (s_rvalid[0][0] !== 1'b1 || s_rdata[0][0] !== 32'hD000_0000 + b) begin n_fail++; $display("FAIL t1_beat%0d got=%b/%h want=1/%h", b, s_rvalid[0][0], s_rdata[0][0], 32'hD000_0000 + b); end
      n_tests++; if (ognt[0] !== 2'b01 || s_rlast[0][0] !== (b == 3)) begin n_fail++; $display("FAIL t1_gnt_last%0d got=%b/%b want=01/%b", b, ognt[0], s_rlast[0][0], b == 3); end
      step();
    end
    m_rvalid[0] = 1'b0;
    m_rlast[0]  = 1'b0;
    #2;
    n_tests++; if (obusy[0] !== 1'b0 || ognt[0] !== 2'b00) begin n_fail++; $display("FAIL t1_idle got=%b/%b want=0/00", obusy[0], ognt[0]); end
    n_tests++; if (oerr[0] !== 1'b0) begin n_fail++; $display("FAIL t1_oerr got=%b want=0", oerr[0]); end
  endtask

  task automatic test_contested();
    do_reset();
    s_arvalid[0][0] = 1'b1; s_araddr[0][0] = 32'h100; s_arlen[0][0] = 8'd1;
    s_arvalid[0][1] = 1'b1; s_araddr[0][1] = 32'h200; s_arlen[0][1] = 8'd1;
    step();
    m_arready[0] = 1'b1;
    #2;
    n_tests++; if (ognt[0] !== 2'b01 || m_araddr[0] !== 32'h100) begin n_fail++; $display("FAIL t2_first got=%b/%h want=01/100", ognt[0], m_araddr[0]); end
    n_tests++; if (s_arready[0][1] !== 1'b0) begin n_fail++; $display("FAIL t2_s1_arready got=%b want=0", s_arready[0][1]); end
    step();
    s_arvalid[0][0] = 1'b0;
    m_arready[0]    = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_rvalid[0] = 1'b1;
      m_rlast[0]  = (b == 1);
      #2;
      n_tests++; if (s_rvalid[0][1] !== 1'b0 || s_rvalid[0][0] !== 1'b1) begin n_fail++; $display("FAIL t2_rvalid%0d got=s1:%b s0:%b want=s1:0 s0:1", b, s_rvalid[0][1], s_rvalid[0][0]); end
      step();
    end
    m_rvalid[0] = 1'b0;
    m_rlast[0]  = 1'b0;
    #2;
    n_tests++; if (obusy[0] !== 1'b0 || m_arvalid[0] !== 1'b0) begin n_fail++; $display("FAIL t2_gap got=%b/%b want=0/0", obusy[0], m_arvalid[0]); end
    step();
    m_arready[0] = 1'b1;
    #2;
    n_tests++; if (ognt[0] !== 2'b10 || m_araddr[0] !== 32'h200 || m_arvalid[0] !== 1'b1) begin n_fail++; $display("FAIL t2_second got=%b/%h/%b want=10/200/1", ognt[0], m_araddr[0], m_arvalid[0]); end
    n_tests++; if (s_arready[0][1] !== 1'b1 || s_arready[0][0] !== 1'b0) begin n_fail++; $display("FAIL t2_arready got=%b%b want=10", s_arready[0][1], s_arready[0][0]); end
    step();
    s_arvalid[0][1] = 1'b0;
    m_arready[0]    = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_rvalid[0] = 1'b1;
      m_rlast[0]  = (b == 1);
      #2;
      n_tests++; if (s_rvalid[0][1] !== 1'b1 || s_rvalid[0][0] !== 1'b0) begin n_fail++; $display("FAIL t2_s1beat%0d got=s1:%b s0:%b want=s1:1 s0:0", b, s_rvalid[0][1], s_rvalid[0][0]); end
      step();
    end
    m_rvalid[0] = 1'b0;
    m_rlast[0]  = 1'b0;
    #2;
    n_tests++; if (obusy[0] !== 1'b0 || oerr[0] !== 1'b0) begin n_fail++; $display("FAIL t2_end got=%b/%b want=0/0", obusy[0], oerr[0]); end
  endtask

  task automatic test_stream(input int g);
    logic [1:0] want;
    bit         found;
    do_reset();
    s_arvalid[g][0] = 1'b1; s_araddr[g][0] = 32'h1000;
    s_arvalid[g][1] = 1'b1; s_araddr[g][1] = 32'h2000;
    m_arready[g]    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      want  = (g == 0 && (k % 2) == 1) ? 2'b10 : 2'b01;
      found = 1'b0;
      for (int t = 0; t < 6 && !found; t++) begin
        #2;
        if (m_arvalid[g] === 1'b1) found = 1'b1;
        else step();
      end
      n_tests++;
      if (!found) begin n_fail++; $display("FAIL t3_timeout inst=%0d burst=%0d got=no_arvalid want=arvalid", g, k); end
      else if (ognt[g] !== want) begin n_fail++; $display("FAIL t3_order inst=%0d burst=%0d got=%b want=%b", g, k, ognt[g], want); end
      step();
      m_rvalid[g] = 1'b1;
      m_rlast[g]  = 1'b1;
      step();
      m_rvalid[g] = 1'b0;
      m_rlast[g]  = 1'b0;
      if (k == 5) begin
        s_arvalid[g][0] = 1'b0;
        s_arvalid[g][1] = 1'b0;
      end
    end
    #2;
    n_tests++; if (oerr[g] !== 1'b0 || obusy[g] !== 1'b0) begin n_fail++; $display("FAIL t3_end inst=%0d got=%b/%b want=0/0", g, oerr[g], obusy[g]); end
  endtask

  task automatic test_retract();
    do_reset();
    s_arvalid[0][1] = 1'b1;
    s_araddr[0][1]  = 32'h300;
    step();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) s_arvalid[0][1] = 1'b0;
      #2;
      n_tests++; if (m_arvalid[0] !== 1'b1 || ognt[0] !== 2'b10 || s_arready[0][1] !== 1'b0) begin n_fail++; $display("FAIL t4_hold%0d got=%b/%b/%b want=1/10/0", c, m_arvalid[0], ognt[0], s_arready[0][1]); end
      n_tests++; if (oerr[0] !== (c >= 3)) begin n_fail++; $display("FAIL t4_oerr%0d got=%b want=%b", c, oerr[0], c >= 3); end
      step();
    end
    m_arready[0] = 1'b1;
    #2;
    n_tests++; if (s_arready[0][1] !== 1'b1 || m_arvalid[0] !== 1'b1) begin n_fail++; $display("FAIL t4_hs got=%b/%b want=1/1", s_arready[0][1], m_arvalid[0]); end
    step();
    m_arready[0] = 1'b0;
    m_rvalid[0]  = 1'b1;
    m_rlast[0]   = 1'b1;
    #2;
    n_tests++; if (s_rvalid[0][1] !== 1'b1 || s_rvalid[0][0] !== 1'b0 || m_arvalid[0] !== 1'b0) begin n_fail++; $display("FAIL t4_r1 got=%b/%b/%b want=1/0/0", s_rvalid[0][1], s_rvalid[0][0], m_arvalid[0]); end
    step();
    m_rvalid[0] = 1'b0;
    m_rlast[0]  = 1'b0;
    #2;
    n_tests++; if (oerr[0] !== 1'b1 || obusy[0] !== 1'b0) begin n_fail++; $display("FAIL t4_end got=%b/%b want=1/0", oerr[0], obusy[0]); end
  endtask

  task automatic test_early_last();
    do_reset();
    s_arvalid[0][0] = 1'b1;
    s_arlen[0][0]   = 8'd3;
    step();
    m_arready[0] = 1'b1;
    step();
    s_arvalid[0][0] = 1'b0;
    m_arready[0]    = 1'b0;
    m_rvalid[0]     = 1'b1;
    step();
    m_rlast[0] = 1'b1;
    #2;
    n_tests++; if (s_rlast[0][0] !== 1'b1 || s_rvalid[0][0] !== 1'b1 || oerr[0] !== 1'b0) begin n_fail++; $display("FAIL t5_beat2 got=%b/%b/%b want=1/1/0", s_rlast[0][0], s_rvalid[0][0], oerr[0]); end
    step();
    m_rvalid[0] = 1'b0;
    m_rlast[0]  = 1'b0;
    #2;
    n_tests++; if (oerr[0] !== 1'b1 || obusy[0] !== 1'b0 || ognt[0] !== 2'b00) begin n_fail++; $display("FAIL t5_after got=%b/%b/%b want=1/0/00", oerr[0], obusy[0], ognt[0]); end
  endtask

  task automatic test_errors();
    do_reset();
    s_arvalid[0][0] = 1'b1;
    s_arlen[0][0]   = 8'd16;
    step();
    m_arready[0] = 1'b1;
    #2;
    n_tests++; if (m_arlen[0] !== 8'd16 || oerr[0] !== 1'b0) begin n_fail++; $display("FAIL te_len_fwd got=%0d/%b want=16/0", m_arlen[0], oerr[0]); end
    step();
    s_arvalid[0][0] = 1'b0;
    m_arready[0]    = 1'b0;
    #2;
    n_tests++; if (oerr[0] !== 1'b1) begin n_fail++; $display("FAIL te_len_err got=%b want=1", oerr[0]); end

    do_reset();
    m_rvalid[0] = 1'b1;
    #2;
    n_tests++; if (s_rvalid[0][0] !== 1'b0 || m_rready[0] !== 1'b0) begin n_fail++; $display("FAIL te_idle_rvalid got=%b/%b want=0/0", s_rvalid[0][0], m_rready[0]); end
    step();
    m_rvalid[0] = 1'b0;
    #2;
    n_tests++; if (oerr[0] !== 1'b1) begin n_fail++; $display("FAIL te_idle_err got=%b want=1", oerr[0]); end

    do_reset();
    s_arvalid[0][0] = 1'b1;
    s_arlen[0][0]   = 8'd0;
    step();
    m_arready[0] = 1'b1;
    step();
    s_arvalid[0][0] = 1'b0;
    m_arready[0]    = 1'b0;
    m_rvalid[0]     = 1'b1;
    step();
    m_rvalid[0] = 1'b0;
    #2;
    n_tests++; if (oerr[0] !== 1'b1 || obusy[0] !== 1'b1) begin n_fail++; $display("FAIL te_nolast got=%b/%b want=1/1", oerr[0], obusy[0]); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    s_arvalid[0][0] = 1'b1;
    s_arlen[0][0]   = 8'd20;
    step();
    m_arready[0] = 1'b1;
    step();
    s_arvalid[0][0] = 1'b0;
    m_arready[0]    = 1'b0;
    m_rvalid[0]     = 1'b1;
    #2;
    n_tests++; if (oerr[0] !== 1'b1 || ognt[0] !== 2'b01) begin n_fail++; $display("FAIL t6_pre got=%b/%b want=1/01", oerr[0], ognt[0]); end
    step();
    rst_n = 1'b0;
    #2;
    n_tests++; if (s_rvalid[0][0] !== 1'b0 || m_rready[0] !== 1'b0) begin n_fail++; $display("FAIL t6_in_rst got=%b/%b want=0/0", s_rvalid[0][0], m_rready[0]); end
    step();
    rst_n       = 1'b1;
    m_rvalid[0] = 1'b0;
    #2;
    n_tests++; if (obusy[0] !== 1'b0 || ognt[0] !== 2'b00 || oerr[0] !== 1'b0) begin n_fail++; $display("FAIL t6_state got=%b/%b/%b want=0/00/0", obusy[0], ognt[0], oerr[0]); end
    n_tests++; if (m_arvalid[0] !== 1'b0 || s_arready[0][0] !== 1'b0 || m_rready[0] !== 1'b0 || s_rvalid[0][0] !== 1'b0) begin n_fail++; $display("FAIL t6_hs got=%b/%b/%b/%b want=0/0/0/0", m_arvalid[0], s_arready[0][0], m_rready[0], s_rvalid[0][0]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_wrap();
    test_contested();
    test_stream(0);
    test_stream(1);
    test_retract();
    test_early_last();
    test_errors();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
